// File: rtl/async_transmitter.sv
// async_transmitter: 8N1 serial transmitter with a small transmit FIFO.
// A fractional baud accumulator produces a one-cycle bit tick. The tick is
// used only as a clock enable. A four-state FSM shifts bytes out LSB first.
// The serial line comes straight from a register, so it cannot glitch.
module async_transmitter #(
  parameter int ClkFrequency          = 24000000,
  parameter int Baud                  = 115200,
  parameter int BaudGeneratorAccWidth = 16,
  parameter int FifoDepth             = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  TxD_data,
  input  logic                        TxD_start,
  output logic                        TxD_ready,
  output logic                        TxD,
  output logic                        TxD_busy,
  output logic [$clog2(FifoDepth):0]  fifo_count
);

  localparam int W  = BaudGeneratorAccWidth;
  localparam int PW = $clog2(FifoDepth);
  localparam int CW = PW + 1;

  // The intermediate is computed at 64 bits so large Baud << (W-4) cannot overflow.
  localparam logic [W-1:0] INC_C = W'(((64'(Baud) << (W - 4)) + (64'(ClkFrequency) >> 5))
                                      / (64'(ClkFrequency) >> 4));
  localparam logic [CW-1:0] DEPTH_C = CW'(FifoDepth);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t          state_r, state_next_s;
  logic [W:0]      acc_r, acc_next_s;
  logic [2:0]      idx_r, idx_next_s;
  logic [7:0]      shift_r, shift_next_s;
  logic            txd_r, txd_next_s;
  logic            tick_s, pop_s, push_s, fifo_empty_s;
  logic [PW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [7:0]      mem_r [FifoDepth];

  assign tick_s       = acc_r[W];
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign push_s       = TxD_start & TxD_ready;

  assign TxD_ready  = (count_r != DEPTH_C);
  assign TxD_busy   = (state_r != ST_IDLE) || !fifo_empty_s;
  assign TxD        = txd_r;
  assign fifo_count = count_r;

  // Frame sequencing: next state, bit index, shift-register load and FIFO pop.
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    shift_next_s = shift_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          shift_next_s = mem_r[rd_ptr_r];
          idx_next_s   = 3'd0;
          state_next_s = ST_START;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s) begin
          idx_next_s   = 3'd0;
          state_next_s = ST_DATA;
        end else begin
          state_next_s = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (idx_r == 3'd7) begin
            state_next_s = ST_STOP;
          end else begin
            idx_next_s = idx_r + 3'd1;
          end
        end else begin
          state_next_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (tick_s) begin
          if (fifo_empty_s) begin
            state_next_s = ST_IDLE;
          end else begin
            // Pop directly into the next start bit: no idle gap between frames.
            pop_s        = 1'b1;
            shift_next_s = mem_r[rd_ptr_r];
            idx_next_s   = 3'd0;
            state_next_s = ST_START;
          end
        end else begin
          state_next_s = ST_STOP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Line level and baud accumulator for the upcoming cycle.
  // The accumulator starts counting on the pop cycle, so each bit lasts 208 or 209 clocks.
  always_comb begin
    txd_next_s = 1'b1;
    if (state_next_s == ST_IDLE) begin
      acc_next_s = {(W + 1){1'b0}};
    end else begin
      acc_next_s = {1'b0, acc_r[W-1:0]} + {1'b0, INC_C};
    end
    case (state_next_s)
      ST_IDLE:  txd_next_s = 1'b1;
      ST_START: txd_next_s = 1'b0;
      ST_DATA:  txd_next_s = shift_next_s[idx_next_s];
      ST_STOP:  txd_next_s = 1'b1;
      default:  txd_next_s = 1'b1;
    endcase
  end

  // Transmitter state registers; reset aborts any frame and forces the line high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      acc_r   <= {(W + 1){1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'd0;
      txd_r   <= 1'b1;
    end else begin
      state_r <= state_next_s;
      acc_r   <= acc_next_s;
      idx_r   <= idx_next_s;
      shift_r <= shift_next_s;
      txd_r   <= txd_next_s;
    end
  end

  // FIFO storage. The contents are qualified by the count, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= TxD_data;
    end
  end

  // FIFO pointers and occupancy. A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_async_transmitter.sv
// Directed bench for async_transmitter: a default-parameter instance is decoded
// by a line monitor. A slow 50 MHz / 9600 baud instance checks its bit period.
module tb_async_transmitter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] TxD_data;
  logic       TxD_start;
  logic       TxD_ready, TxD, TxD_busy;
  logic [2:0] fifo_count;
  logic [7:0] s_data;
  logic       s_start, s_ready, s_txd, s_busy;
  logic [2:0] s_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] rxq[$];
  int         rxs[$];

  async_transmitter dut (
    .clk(clk), .rst_n(rst_n), .TxD_data(TxD_data), .TxD_start(TxD_start),
    .TxD_ready(TxD_ready), .TxD(TxD), .TxD_busy(TxD_busy), .fifo_count(fifo_count)
  );

  async_transmitter #(
    .ClkFrequency(50000000), .Baud(9600), .BaudGeneratorAccWidth(24), .FifoDepth(4)
  ) u_slow (
    .clk(clk), .rst_n(rst_n), .TxD_data(s_data), .TxD_start(s_start),
    .TxD_ready(s_ready), .TxD(s_txd), .TxD_busy(s_busy), .fifo_count(s_count)
  );

  always #5 clk = ~clk;

  // Cycle counter; read at negedges, equals the index of the current cycle.
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: samples each bit near its centre (208.5 clocks per bit) and queues bytes.
  initial begin : monitor
    bit act;
    int cnt, k;
    logic [7:0] sh;
    act = 1'b0; cnt = 0; k = 0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 1'b0;
      end else if (!act) begin
        if (TxD === 1'b0) begin
          act = 1'b1; cnt = 0; k = 1;
          rxs.push_back(cyc);
        end
      end else begin
        cnt++;
        if (cnt == 104 + (417 * k) / 2) begin
          if (k <= 8) begin
            sh[k-1] = TxD;
          end else begin
            tests++;
            if (TxD !== 1'b1) begin
              fails++;
              $display("FAIL stop_bit: got %b want 1", TxD);
            end
            rxq.push_back(sh);
            act = 1'b0;
          end
          k++;
        end
      end
    end
  end

  task automatic clear_q();
    rxq.delete();
    rxs.delete();
  endtask

  task automatic wait_idle(input int budget, output int end_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (TxD_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    end_cyc = cyc;
    tests++;
    if (TxD_busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, want 0", TxD_busy, budget);
    end
  endtask

  task automatic wait_frames(input int nfr, input int budget);
    int n;
    n = 0;
    while (rxq.size() < nfr && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; TxD_start = 1'b0; TxD_data = 8'h00; s_start = 1'b0; s_data = 8'h00;
    repeat (3) @(negedge clk);
    tests += 5;
    if (TxD !== 1'b1) begin fails++; $display("FAIL rst_txd: got %b want 1", TxD); end
    if (TxD_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", TxD_ready); end
    if (TxD_busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", TxD_busy); end
    if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    if (s_txd !== 1'b1) begin fails++; $display("FAIL rst_slow_txd: got %b want 1", s_txd); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int low, end_cyc;
    clear_q();
    TxD_data = 8'hA5; TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    tests += 3;
    if (fifo_count !== 3'd1) begin fails++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
    if (TxD !== 1'b1) begin fails++; $display("FAIL single_line_idle: got %b want 1", TxD); end
    if (TxD_busy !== 1'b1) begin fails++; $display("FAIL single_busy: got %b want 1", TxD_busy); end
    @(negedge clk);
    tests += 2;
    if (fifo_count !== 3'd0) begin fails++; $display("FAIL single_pop: got %0d want 0", fifo_count); end
    if (TxD !== 1'b0) begin fails++; $display("FAIL single_start_bit: got %b want 0", TxD); end
    low = 1;
    @(negedge clk);
    while (TxD === 1'b0 && low < 400) begin
      low++;
      @(negedge clk);
    end
    tests++;
    if (low < 208 || low > 209) begin fails++; $display("FAIL single_start_len: got %0d want 208..209", low); end
    wait_idle(3000, end_cyc);
    tests += 2;
    if (rxq.size() != 1 || rxq[0] !== 8'hA5) begin
      fails++; $display("FAIL single_byte: got %0d bytes first %h want 1 byte a5", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
    if (rxs.size() < 1 || (end_cyc - rxs[0]) < 2075 || (end_cyc - rxs[0]) > 2085) begin
      fails++; $display("FAIL single_frame_len: got %0d want 2075..2085", (rxs.size() > 0) ? end_cyc - rxs[0] : -1);
    end
  endtask

  task automatic test_burst();
    int end_cyc;
    clear_q();
    for (int j = 1; j <= 6; j++) begin
      if (j == 6) begin
        tests += 2;
        if (fifo_count !== 3'd4) begin fails++; $display("FAIL burst_full_count: got %0d want 4", fifo_count); end
        if (TxD_ready !== 1'b0) begin fails++; $display("FAIL burst_ready: got %b want 0", TxD_ready); end
      end
      TxD_data = 8'(j); TxD_start = 1'b1;
      @(negedge clk);
    end
    TxD_start = 1'b0;
    tests++;
    if (fifo_count !== 3'd4) begin fails++; $display("FAIL burst_drop_count: got %0d want 4", fifo_count); end
    wait_frames(5, 12000);
    wait_idle(3000, end_cyc);
    tests++;
    if (rxq.size() != 5) begin fails++; $display("FAIL burst_nbytes: got %0d want 5", rxq.size()); end
    for (int i = 0; i < 5 && i < rxq.size(); i++) begin
      tests++;
      if (rxq[i] !== 8'(i + 1)) begin fails++; $display("FAIL burst_byte%0d: got %h want %h", i, rxq[i], 8'(i + 1)); end
    end
    for (int i = 1; i < 5 && i < rxs.size(); i++) begin
      tests++;
      if ((rxs[i] - rxs[i-1]) < 2079 || (rxs[i] - rxs[i-1]) > 2082) begin
        fails++; $display("FAIL burst_gap%0d: got %0d want 2079..2082", i, rxs[i] - rxs[i-1]);
      end
    end
  endtask

  task automatic test_simul();
    int s, n, end_cyc;
    clear_q();
    TxD_start = 1'b1;
    TxD_data = 8'h11; @(negedge clk);
    TxD_data = 8'h22; @(negedge clk);
    TxD_data = 8'h33; @(negedge clk);
    TxD_start = 1'b0;
    tests++;
    if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_pre_count: got %0d want 2", fifo_count); end
    n = 0;
    while (rxs.size() < 1 && n < 100) begin @(negedge clk); n++; end
    s = (rxs.size() > 0) ? rxs[0] : cyc;
    n = 0;
    while (cyc < s + 2080 && n < 3000) begin @(negedge clk); n++; end
    // This cycle ends on the stop-bit tick that pops 0x22.
    TxD_data = 8'h44; TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    tests += 2;
    if (fifo_count !== 3'd2) begin fails++; $display("FAIL simul_count: got %0d want 2", fifo_count); end
    if (TxD !== 1'b0) begin fails++; $display("FAIL simul_next_start: got %b want 0", TxD); end
    wait_frames(4, 10000);
    wait_idle(3000, end_cyc);
    tests++;
    if (rxq.size() != 4) begin fails++; $display("FAIL simul_nbytes: got %0d want 4", rxq.size()); end
    for (int i = 0; i < 4 && i < rxq.size(); i++) begin
      tests++;
      if (rxq[i] !== 8'(8'h11 * (i + 1))) begin fails++; $display("FAIL simul_byte%0d: got %h want %h", i, rxq[i], 8'(8'h11 * (i + 1))); end
    end
  endtask

  task automatic test_reset_mid();
    int s, n, lows;
    clear_q();
    TxD_start = 1'b1;
    TxD_data = 8'h3C; @(negedge clk);
    TxD_data = 8'hAA; @(negedge clk);
    TxD_data = 8'hBB; @(negedge clk);
    TxD_start = 1'b0;
    n = 0;
    while (rxs.size() < 1 && n < 100) begin @(negedge clk); n++; end
    s = (rxs.size() > 0) ? rxs[0] : cyc;
    n = 0;
    while (cyc < s + 936 && n < 2000) begin @(negedge clk); n++; end
    tests += 2;
    if (TxD !== 1'b1) begin fails++; $display("FAIL mid_bit3: got %b want 1", TxD); end
    if (fifo_count !== 3'd2) begin fails++; $display("FAIL mid_queued: got %0d want 2", fifo_count); end
    rst_n = 1'b0;
    #1;
    tests += 4;
    if (TxD !== 1'b1) begin fails++; $display("FAIL mid_rst_txd: got %b want 1", TxD); end
    if (fifo_count !== 3'd0) begin fails++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
    if (TxD_busy !== 1'b0) begin fails++; $display("FAIL mid_rst_busy: got %b want 0", TxD_busy); end
    if (TxD_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready: got %b want 1", TxD_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    lows = 0;
    repeat (3000) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    tests += 2;
    if (lows != 0 || rxs.size() != 0) begin fails++; $display("FAIL mid_no_frames: got %0d low cycles %0d starts want 0 0", lows, rxs.size()); end
    if (TxD_busy !== 1'b0) begin fails++; $display("FAIL mid_idle_busy: got %b want 0", TxD_busy); end
  endtask

  task automatic test_toggle();
    int n;
    clear_q();
    TxD_data = 8'h81; TxD_start = 1'b1;
    @(negedge clk);
    TxD_start = 1'b0;
    tests++;
    if (fifo_count !== 3'd1) begin fails++; $display("FAIL toggle_count1: got %0d want 1", fifo_count); end
    TxD_data = ~TxD_data;
    @(negedge clk);
    tests++;
    if (TxD !== 1'b0) begin fails++; $display("FAIL toggle_start_bit: got %b want 0", TxD); end
    n = 0;
    while (TxD_busy === 1'b1 && n < 3000) begin
      TxD_data = ~TxD_data;
      @(negedge clk);
      n++;
    end
    tests += 2;
    if (TxD_busy !== 1'b0) begin fails++; $display("FAIL toggle_timeout: busy=%b want 0", TxD_busy); end
    if (rxq.size() != 1 || rxq[0] !== 8'h81) begin
      fails++; $display("FAIL toggle_byte: got %0d bytes first %h want 1 byte 81", rxq.size(), (rxq.size() > 0) ? rxq[0] : 8'hxx);
    end
  endtask

  task automatic test_param();
    int low, high;
    s_data = 8'h55; s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    @(negedge clk);
    tests += 2;
    if (s_txd !== 1'b0) begin fails++; $display("FAIL slow_start_bit: got %b want 0", s_txd); end
    if (s_count !== 3'd0) begin fails++; $display("FAIL slow_pop: got %0d want 0", s_count); end
    low = 1;
    @(negedge clk);
    while (s_txd === 1'b0 && low < 6000) begin low++; @(negedge clk); end
    high = 1;
    @(negedge clk);
    while (s_txd === 1'b1 && high < 6000) begin high++; @(negedge clk); end
    tests += 2;
    if (low < 5205 || low > 5211) begin fails++; $display("FAIL slow_start_len: got %0d want 5205..5211", low); end
    if (high < 5205 || high > 5211) begin fails++; $display("FAIL slow_bit0_len: got %0d want 5205..5211", high); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul();
    test_reset_mid();
    test_toggle();
    test_param();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/async_transmitter.md
ASYNC_TRANSMITTER -- requirements
Module: async_transmitter

Interface
REQ-001 The block SHALL have parameter ClkFrequency, default 24000000, meaning the clk frequency in Hz.
REQ-002 The block SHALL have parameter Baud, default 115200, meaning the line bit rate.
REQ-003 The block SHALL have parameter BaudGeneratorAccWidth, default 16, meaning the baud accumulator width.
REQ-004 The block SHALL have parameter FifoDepth, default 4, meaning the transmit FIFO entries (power of two, 2..16).
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-007 The block SHALL have port TxD_data, input, 8, meaning the byte to send, sampled when TxD_start is high and TxD_ready is high.
REQ-008 The block SHALL have port TxD_start, input, 1, meaning a write request, one byte per high cycle.
REQ-009 The block SHALL have port TxD_ready, output, 1, meaning FIFO not full.
REQ-010 The block SHALL have port TxD, output, 1, meaning the serial line, idle high.
REQ-011 The block SHALL have port TxD_busy, output, 1, meaning a frame is in progress or the FIFO is non-empty.
REQ-012 The block SHALL have port fifo_count, output, clog2(FifoDepth)+1, meaning the number of bytes queued, excluding the frame on the line.

Function
REQ-013 Baud tick: accumulator of BaudGeneratorAccWidth+1 bits; each clk it adds BaudGeneratorInc = ((Baud<<(W-4))+(ClkFrequency>>5))/(ClkFrequency>>4) to the low W bits.
REQ-014 The tick SHALL be accumulator bit W, used as a one-cycle clock enable only, never as a clock.
REQ-015 With the defaults, Inc = 315, so each bit period is 208 or 209 clk cycles.
REQ-016 The accumulator SHALL be held at 0 in IDLE, so the start bit begins on the cycle after the FIFO pop.
REQ-017 Frame format: 8N1, i.e. start bit 0, data bits LSB first, one stop bit 1; no parity.
REQ-018 FSM states: IDLE, START, DATA, STOP.
- IDLE: TxD=1. If FIFO non-empty, pop the head into the shift register and go to START.
- START: TxD=0. On tick, go to DATA with bit index 0.
- DATA: TxD=shift[index]. On tick with index<7, increment the index; on tick with index==7, go to STOP.
- STOP: TxD=1. On tick, go to IDLE if the FIFO is empty; otherwise pop the next byte and go directly to START, giving back-to-back frames with exactly one stop bit.
REQ-019 TxD SHALL be driven from a register so it is glitch-free.
REQ-020 FIFO write: when TxD_start=1 and TxD_ready=1, store TxD_data at the write pointer. TxD_start while full SHALL be ignored: byte dropped, no state change.
REQ-021 Simultaneous write and pop in one cycle SHALL both take effect, with fifo_count unchanged.
REQ-022 Writing into an empty FIFO while in IDLE: the byte is popped on the following cycle.
REQ-023 Pointers SHALL wrap modulo FifoDepth.
REQ-024 fifo_count SHALL range 0..FifoDepth.
REQ-025 TxD_ready = (fifo_count != FifoDepth), combinational from registered state.
REQ-026 TxD_busy = (state != IDLE) or (fifo_count != 0).
REQ-027 TxD_data changing during a frame SHALL not affect the frame, because the shift register holds a private copy.

Reset
REQ-028 While rst_n=0, asynchronously: state=IDLE, TxD=1, accumulator=0, bit index=0, FIFO pointers=0, fifo_count=0, TxD_ready=1, TxD_busy=0.
REQ-029 Reset asserted mid-frame SHALL abort the frame immediately, with TxD high in the same cycle, and discard the queued bytes.
REQ-030 After deassertion, the first write SHALL behave as in REQ-022.

Verification
REQ-031 Single byte 0xA5 written from idle -> TxD frame 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 208/209 clks, total 2080+/-5 clks, then TxD_busy=0.
REQ-032 Five writes on consecutive cycles from idle (0x01..0x05) -> first popped immediately, remaining four fill the FIFO, TxD_ready low once fifo_count=4; a sixth write while full is dropped; line shows 0x01..0x05 back-to-back with no idle gap.
REQ-033 Write on the same cycle as a STOP-to-START pop with fifo_count=2 -> fifo_count stays 2, byte order preserved.
REQ-034 rst_n pulsed low during DATA bit 3 of 0x3C with 2 bytes queued -> TxD=1 same cycle, fifo_count=0, no further frames after release.
REQ-035 Parameters ClkFrequency=50000000, Baud=9600 -> decoded bit period 5208+/-3 clks; a loopback to the team receiver recovers 0x00, 0xFF, 0x55.
REQ-036 TxD_data toggled every cycle during a frame of 0x81 -> line still shows 0x81.
